mp_control_q: RTL and testbench
===============================

Name: mp_control_q

Overview:
- AXI-Lite slave for the job manager; successor to the single-start multi-process control block.
- Holds per-process 64-bit init addresses for 2**PASID_WIDTH processes, written with byte strobes.
- Forwards completion-address writes to the completion RAM.
- Each process-start request is queued in a start FIFO of QUEUE_DEPTH entries. The queue drains downstream over a valid/ready handshake instead of stalling the bus.
- Full-queue starts are rejected with SLVERR and counted. Queue level and overflow count are readable.

Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width (must be >= PID_LSB+PASID_WIDTH).
- DATA_WIDTH, 32, AXI-Lite data width (only 32 supported).
- PASID_WIDTH, 9, process-id width; the block holds 2**PASID_WIDTH processes.
- PID_LSB, 22, lowest address bit of the process id; the offset is addr[PID_LSB-1:0].
- QUEUE_DEPTH, 16, start FIFO depth (power of 2, >= 2).
- PINFO_WIDTH, 88, process_info width (must be >= 72+PASID_WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_axi_aw{valid,ready,addr,prot}: in/out/in/in, 1/1/ADDR_WIDTH/3; AXI-Lite write address channel.
- s_axi_w{valid,ready,data,strb}: in/out/in/in, 1/1/32/4; AXI-Lite write data channel.
- s_axi_b{valid,ready,resp}: out/in/out, 1/1/2; AXI-Lite write response channel.
- s_axi_ar{valid,ready,addr,prot}: in/out/in/in, 1/1/ADDR_WIDTH/3; AXI-Lite read address channel.
- s_axi_r{valid,ready,data,resp}: out/in/out/out, 1/1/32/2; AXI-Lite read data channel.
- cmpl_ram_addr_o  out  PASID_WIDTH  process id of the completion write
- cmpl_ram_lo_o / cmpl_ram_hi_o  out  1  one-cycle write strobes for the low / high completion word
- cmpl_ram_data_o  out  32  completion write data
- cmpl_ram_strb_o  out  4  completion write byte enables
- process_info_o  out  PINFO_WIDTH  {zero pad, CONTROL[15:8], pid, init_addr[63:0]}
- process_valid_o  out  1  FIFO not empty
- process_ready_i  in  1  downstream accept
- i_action_type / i_action_version  in  32  read-only identification values

Behaviour:
- Reset values: all ready, valid and strobe outputs 0, except awready, wready and arready, which are 1. rdata=0, resp=0, FIFO empty, overflow count 0, CONTROL shadow 0. Init RAM is not reset.
- Offsets (per process, pid = addr[PID_LSB+PASID_WIDTH-1:PID_LSB]):
  - 0x00 ACTION_TYPE (RO)
  - 0x04 ACTION_VERSION (RO)
  - 0x24 CONTROL (WO; a write starts the process)
  - 0x28 INIT_LO (RW)
  - 0x2C INIT_HI (RW)
  - 0x30 CMPL_LO (WO)
  - 0x34 CMPL_HI (WO)
  - 0x38 QSTATUS (RO, global): [15:0] fill level, [31:16] saturating overflow count
- Write FSM:
  - W_IDLE (awready=wready=1). AW and W handshakes may arrive in either order.
  - An AW-only handshake latches the address and moves to W_WAIT_W (awready=0).
  - A W-only handshake latches data and strobe and moves to W_WAIT_A (wready=0).
  - When both handshakes are complete, the block issues a one-cycle commit and moves to W_RESP: bvalid=1 in the cycle after the final handshake, held until bready, then W_IDLE.
  - Only one write is outstanding at a time.
- Commit actions:
  - INIT_LO/HI: byte-masked write of the init RAM at pid.
  - CMPL_LO/HI: pulse cmpl_ram_lo_o/hi_o for exactly one cycle, together with addr, data and strb.
  - CONTROL: snapshot {wdata[15:8], pid, init_addr} into the FIFO.
    - The enqueue is accepted if the FIFO is not full, or if a dequeue (valid&ready) occurs in the same cycle; bresp=OKAY.
    - Otherwise the start is dropped, the overflow count increments (saturating at 0xFFFF) and bresp=SLVERR (2'b10).
  - Writes to RO or unmapped offsets: ignored, bresp=OKAY.
- Read FSM:
  - R_IDLE (arready=1). On handshake, decode and register rdata; rvalid=1 in the next cycle, arready=0. Hold until rready, then arready=1.
  - Unmapped or write-only offsets return 0x5a5aa5a5. rresp is always OKAY.
  - A read accepted in the same cycle as a write commit to the same location returns the pre-write value.
- FIFO: first-in first-out; process_info_o is the head entry; pops on valid&ready. A simultaneous push and pop keeps the level unchanged.
- The init_addr snapshot is taken at commit, so later INIT writes do not alter queued entries.
- Reset asserted mid-transaction: both FSMs return to idle, pending responses are dropped, the FIFO is flushed and the counters are cleared.

Decomposition:
- mp_control_pkg holds the offset constants, the SLVERR/OKAY codes, the QSTATUS field positions and the write/read FSM state enums.
- Sub-module mp_start_fifo (parametrised width/depth, valid/ready output, full/level/push-accept outputs).
- The init RAM is inferred inline as 4 byte-lanes x 2 words.

Test Plan:
- Reset, then read 0x00 and 0x04 with i_action_type=0x10143008 -> rdata 0x10143008, then i_action_version; rresp=0. A read of offset 0x3C returns 0x5a5aa5a5.
- pid=5 (addr 0x01400028): write INIT_LO=0xDEADBEEF with strb=0xF, then rewrite with strb=0x1 and wdata=0x11 -> readback 0xDEADBE11.
- pid=3: INIT_HI=0x1, INIT_LO=0x1000, then CONTROL wdata=0x0000AB00 with process_ready_i=0 -> process_valid_o=1 and process_info_o = {pad, 8'hAB, 9'd3, 64'h0000_0001_0000_1000}; QSTATUS=0x00000001.
- Hold process_ready_i=0 and issue 17 CONTROL writes with QUEUE_DEPTH=16 -> the first 16 get bresp=0, the 17th gets bresp=2, and QSTATUS=0x00010010. A CONTROL write while full with process_ready_i=1 gets bresp=0 and the level stays 16.
- W before AW by 3 cycles to CMPL_HI at pid=7 -> a single cmpl_ram_hi_o pulse with cmpl_ram_addr_o=7; bvalid asserts the cycle after the AW handshake. Hold bready=0 for 4 cycles -> bvalid stays high and awready=0.
- Assert rst while 2 entries are queued and a read is pending -> process_valid_o=0, rvalid=0, arready=1 immediately; after release QSTATUS reads 0.

Source files
------------

// File: rtl/mp_control_pkg.sv
// Shared constants and FSM state types for the multi-process control slave.
package mp_control_pkg;

  // Per-process register offsets (low address bits below the process id).
  localparam logic [7:0] OffActionType    = 8'h00;
  localparam logic [7:0] OffActionVersion = 8'h04;
  localparam logic [7:0] OffControl       = 8'h24;
  localparam logic [7:0] OffInitLo        = 8'h28;
  localparam logic [7:0] OffInitHi        = 8'h2C;
  localparam logic [7:0] OffCmplLo        = 8'h30;
  localparam logic [7:0] OffCmplHi        = 8'h34;
  localparam logic [7:0] OffQstatus       = 8'h38;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // QSTATUS layout: fill level in the low half, overflow count in the high half.
  localparam int unsigned QstatLevelLsb = 0;
  localparam int unsigned QstatOvfLsb   = 16;
  localparam int unsigned QstatFieldW   = 16;

  // Returned for unmapped and write-only offsets.
  localparam logic [31:0] RdataUnmapped = 32'h5a5a_a5a5;

  typedef enum logic [1:0] {
    WIdle,
    WWaitW,
    WWaitA,
    WResp
  } w_state_e;

  typedef enum logic {
    RIdle,
    RResp
  } r_state_e;

endpackage

// File: rtl/mp_control_q_if.sv
// AXI-Lite bundle between the job manager and the control slave.
interface mp_control_q_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/mp_start_fifo.sv
// Start-request FIFO with a valid/ready drain port; a push into a full FIFO is
// accepted only when the head is popped in the same cycle.
module mp_start_fifo #(
  parameter int unsigned Width = 81,
  parameter int unsigned Depth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [Width-1:0]       push_data_i,
  output logic                   push_accept_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [Width-1:0]       data_o,
  output logic                   full_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    level_q;
  logic             push, pop;

  assign full_o        = (level_q == (PtrW + 1)'(Depth));
  assign valid_o       = (level_q != '0);
  assign pop           = valid_o && ready_i;
  assign push          = push_i && (!full_o || pop);
  assign push_accept_o = push;
  assign data_o        = mem_q[rd_ptr_q];
  assign level_o       = level_q;

  // Pointers and fill level; push+pop together leaves the level unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // Entry storage; contents are don't-care while unoccupied so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mp_control_q.sv
// AXI-Lite control slave: per-process init addresses, completion-RAM forwarding
// and a queued process-start path with overflow accounting.
module mp_control_q
  import mp_control_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PASID_WIDTH = 9,
  parameter int unsigned PID_LSB     = 22,
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned PINFO_WIDTH = 88
) (
  input  logic                   clk,
  input  logic                   rst,
  mp_control_q_if.slave          s_axi,
  output logic [PASID_WIDTH-1:0] cmpl_ram_addr_o,
  output logic                   cmpl_ram_lo_o,
  output logic                   cmpl_ram_hi_o,
  output logic [31:0]            cmpl_ram_data_o,
  output logic [3:0]             cmpl_ram_strb_o,
  output logic [PINFO_WIDTH-1:0] process_info_o,
  output logic                   process_valid_o,
  input  logic                   process_ready_i,
  input  logic [31:0]            i_action_type,
  input  logic [31:0]            i_action_version
);

  localparam int unsigned NumProc = 2 ** PASID_WIDTH;
  localparam int unsigned EntryW  = 72 + PASID_WIDTH;
  localparam int unsigned LevelW  = $clog2(QUEUE_DEPTH) + 1;

  // Write path
  w_state_e               w_state_q, w_state_d;
  logic                   awready, wready, bvalid, commit;
  logic                   aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0]  awaddr_q, w_addr;
  logic [DATA_WIDTH-1:0]  wdata_q, w_data;
  logic [3:0]             wstrb_q, w_strb;
  logic [PASID_WIDTH-1:0] w_pid;
  logic [PID_LSB-1:0]     w_off;
  logic [1:0]             bresp_q, bresp_d;
  logic                   wr_init_lo, wr_init_hi, wr_cmpl_lo, wr_cmpl_hi, wr_control;

  // Read path
  r_state_e               r_state_q, r_state_d;
  logic                   arready, rvalid, ar_hs;
  logic [PASID_WIDTH-1:0] r_pid;
  logic [PID_LSB-1:0]     r_off;
  logic [31:0]            rdata_q, rdata_d, qstatus;

  // Storage, queue and counters
  logic [31:0]            init_lo_mem [NumProc];
  logic [31:0]            init_hi_mem [NumProc];
  logic [EntryW-1:0]      fifo_wdata, fifo_rdata;
  logic                   fifo_accept, fifo_full;
  logic [LevelW-1:0]      fifo_level;
  logic [15:0]            ovf_q;
  logic                   cmpl_lo_q, cmpl_hi_q;
  logic [PASID_WIDTH-1:0] cmpl_addr_q;
  logic [31:0]            cmpl_data_q;
  logic [3:0]             cmpl_strb_q;

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RespOkay;

  assign aw_hs = s_axi.awvalid && awready;
  assign w_hs  = s_axi.wvalid && wready;

  // Commit uses whichever half of the write arrived earlier from its latch.
  assign w_addr = (w_state_q == WWaitW) ? awaddr_q : s_axi.awaddr;
  assign w_data = (w_state_q == WWaitA) ? wdata_q  : s_axi.wdata;
  assign w_strb = (w_state_q == WWaitA) ? wstrb_q  : s_axi.wstrb;
  assign w_pid  = w_addr[PID_LSB +: PASID_WIDTH];
  assign w_off  = w_addr[PID_LSB-1:0];

  assign wr_control = commit && (w_off == PID_LSB'(OffControl));
  assign wr_init_lo = commit && (w_off == PID_LSB'(OffInitLo));
  assign wr_init_hi = commit && (w_off == PID_LSB'(OffInitHi));
  assign wr_cmpl_lo = commit && (w_off == PID_LSB'(OffCmplLo));
  assign wr_cmpl_hi = commit && (w_off == PID_LSB'(OffCmplHi));

  assign bresp_d = (wr_control && !fifo_accept) ? RespSlverr : RespOkay;

  // Snapshot of the init address at commit; later INIT writes leave it alone.
  assign fifo_wdata = {w_data[15:8], w_pid, init_hi_mem[w_pid], init_lo_mem[w_pid]};

  // Write FSM next state, channel readies and commit strobe
  always_comb begin
    w_state_d = w_state_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    commit    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (s_axi.awvalid && s_axi.wvalid) begin
          commit    = 1'b1;
          w_state_d = WResp;
        end else if (s_axi.awvalid) begin
          w_state_d = WWaitW;
        end else if (s_axi.wvalid) begin
          w_state_d = WWaitA;
        end
      end
      WWaitW: begin
        wready = 1'b1;
        if (s_axi.wvalid) begin
          commit    = 1'b1;
          w_state_d = WResp;
        end
      end
      WWaitA: begin
        awready = 1'b1;
        if (s_axi.awvalid) begin
          commit    = 1'b1;
          w_state_d = WResp;
        end
      end
      WResp: begin
        bvalid = 1'b1;
        if (s_axi.bready) w_state_d = WIdle;
      end
    endcase
  end

  // Write FSM state, half-transaction latches and response code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= WIdle;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) awaddr_q <= s_axi.awaddr;
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (commit) bresp_q <= bresp_d;
    end
  end

  // Byte-masked init address writes; storage is deliberately not reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_init_lo && w_strb[b]) init_lo_mem[w_pid][8*b +: 8] <= w_data[8*b +: 8];
      if (wr_init_hi && w_strb[b]) init_hi_mem[w_pid][8*b +: 8] <= w_data[8*b +: 8];
    end
  end

  // One-cycle completion-RAM write strobes with their address, data and enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmpl_lo_q   <= 1'b0;
      cmpl_hi_q   <= 1'b0;
      cmpl_addr_q <= '0;
      cmpl_data_q <= '0;
      cmpl_strb_q <= '0;
    end else begin
      cmpl_lo_q <= wr_cmpl_lo;
      cmpl_hi_q <= wr_cmpl_hi;
      if (wr_cmpl_lo || wr_cmpl_hi) begin
        cmpl_addr_q <= w_pid;
        cmpl_data_q <= w_data[31:0];
        cmpl_strb_q <= w_strb;
      end
    end
  end

  assign cmpl_ram_lo_o   = cmpl_lo_q;
  assign cmpl_ram_hi_o   = cmpl_hi_q;
  assign cmpl_ram_addr_o = cmpl_addr_q;
  assign cmpl_ram_data_o = cmpl_data_q;
  assign cmpl_ram_strb_o = cmpl_strb_q;

  // Saturating count of starts dropped because the queue was full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (wr_control && !fifo_accept && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  mp_start_fifo #(
    .Width (EntryW),
    .Depth (QUEUE_DEPTH)
  ) u_start_fifo (
    .clk           (clk),
    .rst           (rst),
    .push_i        (wr_control),
    .push_data_i   (fifo_wdata),
    .push_accept_o (fifo_accept),
    .valid_o       (process_valid_o),
    .ready_i       (process_ready_i),
    .data_o        (fifo_rdata),
    .full_o        (fifo_full),
    .level_o       (fifo_level)
  );

  assign process_info_o = PINFO_WIDTH'(fifo_rdata);

  assign r_pid = s_axi.araddr[PID_LSB +: PASID_WIDTH];
  assign r_off = s_axi.araddr[PID_LSB-1:0];

  // Read decode; RAM is sampled before any same-cycle write lands
  always_comb begin
    qstatus = '0;
    qstatus[QstatLevelLsb +: QstatFieldW] = QstatFieldW'(fifo_level);
    qstatus[QstatOvfLsb +: QstatFieldW]   = ovf_q;
    rdata_d = RdataUnmapped;
    case (r_off)
      PID_LSB'(OffActionType):    rdata_d = i_action_type;
      PID_LSB'(OffActionVersion): rdata_d = i_action_version;
      PID_LSB'(OffInitLo):        rdata_d = init_lo_mem[r_pid];
      PID_LSB'(OffInitHi):        rdata_d = init_hi_mem[r_pid];
      PID_LSB'(OffQstatus):       rdata_d = qstatus;
      default:                    rdata_d = RdataUnmapped;
    endcase
  end

  // Read FSM next state and channel handshakes
  always_comb begin
    r_state_d = r_state_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    ar_hs     = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        arready = 1'b1;
        if (s_axi.arvalid) begin
          ar_hs     = 1'b1;
          r_state_d = RResp;
        end
      end
      RResp: begin
        rvalid = 1'b1;
        if (s_axi.rready) r_state_d = RIdle;
      end
    endcase
  end

  // Read FSM state and registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= RIdle;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) rdata_q <= rdata_d;
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{s_axi.awprot, s_axi.arprot, fifo_full, w_addr, s_axi.araddr};

endmodule

// File: tb/tb_mp_control_q.sv
// Directed bench for mp_control_q: register access, start queue, completion
// forwarding and mid-transaction reset.
module tb_mp_control_q;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  cmpl_ram_addr;
  logic        cmpl_ram_lo, cmpl_ram_hi;
  logic [31:0] cmpl_ram_data;
  logic [3:0]  cmpl_ram_strb;
  logic [87:0] process_info;
  logic        process_valid;
  logic        process_ready;
  logic [31:0] action_type, action_version;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  mp_control_q_if #(.ADDR_WIDTH(32)) s_axi ();

  mp_control_q #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .PASID_WIDTH (9),
    .PID_LSB     (22),
    .QUEUE_DEPTH (16),
    .PINFO_WIDTH (88)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axi            (s_axi),
    .cmpl_ram_addr_o  (cmpl_ram_addr),
    .cmpl_ram_lo_o    (cmpl_ram_lo),
    .cmpl_ram_hi_o    (cmpl_ram_hi),
    .cmpl_ram_data_o  (cmpl_ram_data),
    .cmpl_ram_strb_o  (cmpl_ram_strb),
    .process_info_o   (process_info),
    .process_valid_o  (process_valid),
    .process_ready_i  (process_ready),
    .i_action_type    (action_type),
    .i_action_version (action_version)
  );

  task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] reg_addr(input int pid, input logic [7:0] off);
    return (32'(pid) << 22) | 32'(off);
  endfunction

  // Both halves presented together; optionally pulses process_ready for the
  // handshake cycle so a dequeue coincides with the commit.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit pulse_rdy,
                           output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs, b_done;
    s_axi.awaddr  = addr;
    s_axi.wdata   = data;
    s_axi.wstrb   = strb;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    s_axi.bready  = 1'b1;
    if (pulse_rdy) process_ready = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_hs = s_axi.awvalid && s_axi.awready;
      w_hs  = s_axi.wvalid && s_axi.wready;
      @(posedge clk);
      #1;
      if (pulse_rdy) process_ready = 1'b0;
      if (aw_hs) begin aw_done = 1'b1; s_axi.awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; s_axi.wvalid  = 1'b0; end
    end
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    check("write_addr_data_handshake", 88'(aw_done && w_done), 88'(1));
    resp   = 2'bxx;
    b_done = 1'b0;
    for (int i = 0; i < 20 && !b_done; i++) begin
      if (s_axi.bvalid) begin
        resp   = s_axi.bresp;
        b_done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_axi.bready = 1'b0;
    check("write_response_handshake", 88'(b_done), 88'(1));
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_done, r_done;
    s_axi.araddr  = addr;
    s_axi.arvalid = 1'b1;
    s_axi.rready  = 1'b1;
    ar_done = 1'b0;
    for (int i = 0; i < 20 && !ar_done; i++) begin
      ar_done = s_axi.arready;
      @(posedge clk);
      #1;
    end
    s_axi.arvalid = 1'b0;
    check("read_addr_handshake", 88'(ar_done), 88'(1));
    data   = 32'hxxxx_xxxx;
    resp   = 2'bxx;
    r_done = 1'b0;
    for (int i = 0; i < 20 && !r_done; i++) begin
      if (s_axi.rvalid) begin
        data   = s_axi.rdata;
        resp   = s_axi.rresp;
        r_done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_axi.rready = 1'b0;
    check("read_data_handshake", 88'(r_done), 88'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [87:0] exp_info;
    int          hi_pulses;

    s_axi.awvalid = 1'b0;
    s_axi.awaddr  = '0;
    s_axi.awprot  = '0;
    s_axi.wvalid  = 1'b0;
    s_axi.wdata   = '0;
    s_axi.wstrb   = '0;
    s_axi.bready  = 1'b0;
    s_axi.arvalid = 1'b0;
    s_axi.araddr  = '0;
    s_axi.arprot  = '0;
    s_axi.rready  = 1'b0;
    process_ready  = 1'b0;
    action_type    = 32'h1014_3008;
    action_version = 32'h0000_0102;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", 88'(s_axi.awready), 88'(1));
    check("rst_wready", 88'(s_axi.wready), 88'(1));
    check("rst_arready", 88'(s_axi.arready), 88'(1));
    check("rst_bvalid", 88'(s_axi.bvalid), 88'(0));
    check("rst_rvalid", 88'(s_axi.rvalid), 88'(0));
    check("rst_rdata", 88'(s_axi.rdata), 88'(0));
    check("rst_process_valid", 88'(process_valid), 88'(0));
    check("rst_cmpl_strobes", 88'({cmpl_ram_lo, cmpl_ram_hi}), 88'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Identification reads and an unmapped offset
    axi_read(reg_addr(0, 8'h00), rdata, resp);
    check("action_type", 88'(rdata), 88'(32'h1014_3008));
    check("action_type_rresp", 88'(resp), 88'(0));
    axi_read(reg_addr(0, 8'h04), rdata, resp);
    check("action_version", 88'(rdata), 88'(32'h0000_0102));
    axi_read(reg_addr(0, 8'h3C), rdata, resp);
    check("unmapped_read", 88'(rdata), 88'(32'h5a5a_a5a5));

    // Byte-masked INIT_LO at pid 5
    axi_write(reg_addr(5, 8'h28), 32'hDEAD_BEEF, 4'hF, 1'b0, resp);
    check("init_lo_bresp", 88'(resp), 88'(0));
    axi_write(reg_addr(5, 8'h28), 32'h0000_0011, 4'h1, 1'b0, resp);
    axi_read(reg_addr(5, 8'h28), rdata, resp);
    check("init_lo_bytemask", 88'(rdata), 88'(32'hDEAD_BE11));

    // Start of pid 3 captures its init address
    axi_write(reg_addr(3, 8'h2C), 32'h0000_0001, 4'hF, 1'b0, resp);
    axi_write(reg_addr(3, 8'h28), 32'h0000_1000, 4'hF, 1'b0, resp);
    axi_write(reg_addr(3, 8'h24), 32'h0000_AB00, 4'hF, 1'b0, resp);
    check("control_bresp", 88'(resp), 88'(0));
    check("control_valid", 88'(process_valid), 88'(1));
    exp_info = {7'd0, 8'hAB, 9'd3, 64'h0000_0001_0000_1000};
    check("control_info", process_info, exp_info);
    axi_read(reg_addr(0, 8'h38), rdata, resp);
    check("qstatus_one", 88'(rdata), 88'(32'h0000_0001));

    // Drain that entry
    process_ready = 1'b1;
    @(posedge clk);
    #1;
    process_ready = 1'b0;
    check("drained_one", 88'(process_valid), 88'(0));

    // Fill the queue and overflow by one
    for (int i = 0; i < 17; i++) begin
      axi_write(reg_addr(0, 8'h24), 32'(i) << 8, 4'hF, 1'b0, resp);
      check($sformatf("fill_bresp_%0d", i), 88'(resp), (i < 16) ? 88'(0) : 88'(2));
    end
    axi_read(reg_addr(0, 8'h38), rdata, resp);
    check("qstatus_full_ovf", 88'(rdata), 88'(32'h0001_0010));

    // Start while full but with a same-cycle dequeue is accepted
    axi_write(reg_addr(0, 8'h24), 32'h0000_EE00, 4'hF, 1'b1, resp);
    check("full_with_pop_bresp", 88'(resp), 88'(0));
    check("fifo_order_ctrl", 88'(process_info[80:73]), 88'(8'h01));
    check("fifo_order_pid", 88'(process_info[72:64]), 88'(0));
    axi_read(reg_addr(0, 8'h38), rdata, resp);
    check("qstatus_after_pop_push", 88'(rdata), 88'(32'h0001_0010));

    process_ready = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    process_ready = 1'b0;
    check("drained_all", 88'(process_valid), 88'(0));

    // W ahead of AW to CMPL_HI at pid 7, response held off for 4 cycles
    s_axi.wdata  = 32'hCAFE_0001;
    s_axi.wstrb  = 4'hC;
    s_axi.wvalid = 1'b1;
    @(posedge clk);
    #1;
    s_axi.wvalid = 1'b0;
    check("w_first_wready_low", 88'(s_axi.wready), 88'(0));
    check("w_first_no_bvalid", 88'(s_axi.bvalid), 88'(0));
    repeat (2) @(posedge clk);
    #1;
    s_axi.awaddr  = reg_addr(7, 8'h34);
    s_axi.awvalid = 1'b1;
    @(posedge clk);
    #1;
    s_axi.awvalid = 1'b0;
    check("cmpl_bvalid", 88'(s_axi.bvalid), 88'(1));
    check("cmpl_bresp", 88'(s_axi.bresp), 88'(0));
    check("cmpl_hi_pulse", 88'(cmpl_ram_hi), 88'(1));
    check("cmpl_lo_quiet", 88'(cmpl_ram_lo), 88'(0));
    check("cmpl_addr", 88'(cmpl_ram_addr), 88'(9'd7));
    check("cmpl_data", 88'(cmpl_ram_data), 88'(32'hCAFE_0001));
    check("cmpl_strb", 88'(cmpl_ram_strb), 88'(4'hC));
    hi_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (cmpl_ram_hi) hi_pulses++;
      check($sformatf("bvalid_held_%0d", i), 88'(s_axi.bvalid), 88'(1));
      check($sformatf("awready_held_%0d", i), 88'(s_axi.awready), 88'(0));
    end
    check("cmpl_single_pulse", 88'(hi_pulses), 88'(0));
    s_axi.bready = 1'b1;
    @(posedge clk);
    #1;
    s_axi.bready = 1'b0;
    check("bvalid_released", 88'(s_axi.bvalid), 88'(0));
    check("awready_restored", 88'(s_axi.awready), 88'(1));

    // Reset with two queued starts and a read response pending
    axi_write(reg_addr(1, 8'h24), 32'h0000_0100, 4'hF, 1'b0, resp);
    axi_write(reg_addr(2, 8'h24), 32'h0000_0200, 4'hF, 1'b0, resp);
    s_axi.araddr  = reg_addr(0, 8'h38);
    s_axi.arvalid = 1'b1;
    @(posedge clk);
    #1;
    s_axi.arvalid = 1'b0;
    check("pre_reset_rvalid", 88'(s_axi.rvalid), 88'(1));
    rst = 1'b1;
    #1;
    check("midrst_process_valid", 88'(process_valid), 88'(0));
    check("midrst_rvalid", 88'(s_axi.rvalid), 88'(0));
    check("midrst_arready", 88'(s_axi.arready), 88'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    axi_read(reg_addr(0, 8'h38), rdata, resp);
    check("qstatus_after_reset", 88'(rdata), 88'(0));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
